coin_sense: RTL

//   Coin-sensor front end for the vending FSM. Synchronises and debounces the two raw coin

---
 rtl/coin_sense.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/coin_sense.sv
// Coin-sensor front end: per-channel synchroniser + debounce FSM, 1.0-first arbitration, busy reject.
// Optional feature macro: COIN_TALLY_EN adds saturating forwarded-coin tally outputs.

// State table for coin_chan:
//   state      | meaning
//   S_IDLE     | sensor settled low, waiting for a rising level
//   S_ARM      | sensor high, counting stable high cycles
//   S_HELD     | coin accepted, waiting for sensor to drop
//   S_WAIT_LOW | counting stable low cycles before re-arming (also the reset state)
module coin_chan #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic coin_event
);
    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARM      = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_WAIT_LOW = 2'd3;

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT_LOW;
            coin_event <= 1'b0;
        end else begin
            sync_a     <= raw;
            sync_b     <= sync_a;
            coin_event <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_b) begin
                        state <= S_ARM;
                        cnt   <= '0;
                    end
                end
                S_ARM: begin
                    if (!sync_b) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= S_HELD;
                        coin_event <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!sync_b) begin
                        state <= S_WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                default: begin
                    // any high sample restarts the low-stability window
                    if (sync_b) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module coin_sense #(
    parameter int DEB_CYCLES = 8,
    parameter int TALLY_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_half_raw,
    input  logic       coin_one_raw,
    input  logic       busy,
    output logic [1:0] coin_out,
    output logic       reject_out
`ifdef COIN_TALLY_EN
    ,
    output logic [TALLY_W-1:0] tally_half,
    output logic [TALLY_W-1:0] tally_one
`endif
);
    if (DEB_CYCLES < 2 || TALLY_W < 1) begin : g_param_check
        $error("coin_sense: DEB_CYCLES must be >= 2 and TALLY_W >= 1");
    end

    logic       ev_half;
    logic       ev_one;
    logic       pend_half;
    logic       pend_half_next;
    logic [1:0] issue;

    coin_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan_half (
        .clk        (clk),
        .rst        (rst),
        .raw        (coin_half_raw),
        .coin_event (ev_half)
    );

    coin_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan_one (
        .clk        (clk),
        .rst        (rst),
        .raw        (coin_one_raw),
        .coin_event (ev_one)
    );

    // 1.0 wins a collision; the 0.5 coin waits one cycle in pend_half
    always_comb begin
        issue          = 2'b00;
        pend_half_next = 1'b0;
        if (ev_one) begin
            issue          = 2'b10;
            pend_half_next = ev_half | pend_half;
        end else if (ev_half || pend_half) begin
            issue = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_out   <= 2'b00;
            reject_out <= 1'b0;
            pend_half  <= 1'b0;
        end else begin
            pend_half  <= pend_half_next;
            coin_out   <= busy ? 2'b00 : issue;
            reject_out <= busy & (|issue);
        end
    end

`ifdef COIN_TALLY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tally_half <= '0;
            tally_one  <= '0;
        end else if (!busy) begin
            if (issue[0] && (tally_half != {TALLY_W{1'b1}})) begin
                tally_half <= tally_half + 1'b1;
            end
            if (issue[1] && (tally_one != {TALLY_W{1'b1}})) begin
                tally_one <= tally_one + 1'b1;
            end
        end
    end
`endif
endmodule
